jpeg_fb_writer: RTL and testbench

JPEG_FB_WRITER -- requirements
Module: jpeg_fb_writer

---
 rtl/jpeg_fb_writer.sv | 157 +++++++++++++++
 tb/tb_jpeg_fb_writer.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_fb_writer.sv
// Pixel-to-framebuffer writer: places decoded JPEG pixels into DDRAM words,
// coalescing pixels that land in the same 64-bit word into a single masked write.
//
// state    | meaning
// EMPTY    | no buffered word; accepting pixels
// FILL     | word buffered; hits merge, a miss is parked in the pending slot
// WRITE    | buffered word presented to DDRAM until accepted
module jpeg_fb_writer #(
    parameter int ADDR_W        = 29,
    parameter int COORD_W       = 16,
    parameter int BPP           = 32,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [13:0]       stride_i,
    input  logic              pix_valid_i,
    output logic              pix_accept_o,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    input  logic [7:0]        pix_r_i,
    input  logic [7:0]        pix_g_i,
    input  logic [7:0]        pix_b_i,
    input  logic              flush_i,
    input  logic              ddr_busy_i,
    output logic              ddr_we_o,
    output logic [ADDR_W-1:0] ddr_addr_o,
    output logic [63:0]       ddr_din_o,
    output logic [7:0]        ddr_be_o,
    output logic [7:0]        ddr_burstcnt_o,
    output logic              idle_o,
    output logic [31:0]       wr_count_o
);

    // one spare bit so y*stride + x*bytes can never wrap
    localparam int OFF_W = COORD_W + 15;
    localparam int TMR_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] buf_addr;
    logic [63:0]       buf_data;
    logic [7:0]        buf_mask;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [63:0]       pend_data;
    logic [7:0]        pend_mask;
    logic [TMR_W-1:0]  tmr;

    logic [OFF_W-1:0]  pix_off;
    logic [ADDR_W-1:0] pix_word;
    logic [63:0]       pix_data;
    logic [63:0]       pix_bmask;
    logic [7:0]        pix_mask;
    logic [31:0]       rgba;
    logic [15:0]       rgb565;
    logic              pix_take;
    logic              pix_hit;
    logic              tmr_expire;

    always_comb begin
        pix_off  = OFF_W'(pix_y_i) * OFF_W'(stride_i)
                 + (OFF_W'(pix_x_i) << ((BPP == 32) ? 2 : 1));
        pix_word = base_i + ADDR_W'(pix_off >> 3);
        rgba     = {8'hFF, pix_b_i, pix_g_i, pix_r_i};
        rgb565   = {pix_r_i[7:3], pix_g_i[7:2], pix_b_i[7:3]};
        if (BPP == 32) begin
            pix_data = pix_off[2] ? {rgba, 32'h0} : {32'h0, rgba};
            pix_mask = pix_off[2] ? 8'hF0 : 8'h0F;
        end else begin
            pix_data = 64'(rgb565) << {pix_off[2:1], 4'b0000};
            pix_mask = 8'h03 << {pix_off[2:1], 1'b0};
        end
        pix_bmask = '0;
        for (int i = 0; i < 8; i++) begin
            pix_bmask[i*8 +: 8] = {8{pix_mask[i]}};
        end
    end

    assign pix_accept_o   = !rst_i && (state != ST_WRITE);
    assign idle_o         = !rst_i && (state == ST_EMPTY);
    assign pix_take       = pix_valid_i && pix_accept_o;
    assign pix_hit        = (state == ST_FILL) && (pix_word == buf_addr);
    assign tmr_expire     = (FLUSH_TIMEOUT != 0) && (tmr == TMR_W'(1));
    assign ddr_we_o       = (state == ST_WRITE);
    assign ddr_addr_o     = buf_addr;
    assign ddr_din_o      = buf_data;
    assign ddr_be_o       = buf_mask;
    assign ddr_burstcnt_o = 8'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_EMPTY;
            buf_addr   <= '0;
            buf_data   <= '0;
            buf_mask   <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            pend_mask  <= '0;
            tmr        <= '0;
            wr_count_o <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (pix_take) begin
                        buf_addr <= pix_word;
                        buf_data <= pix_data;
                        buf_mask <= pix_mask;
                        tmr      <= TMR_W'(FLUSH_TIMEOUT);
                        state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (pix_take) begin
                        tmr <= TMR_W'(FLUSH_TIMEOUT);
                        if (pix_hit) begin
                            buf_data <= (buf_data & ~pix_bmask) | pix_data;
                            buf_mask <= buf_mask | pix_mask;
                            if (flush_i) state <= ST_WRITE;
                        end else begin
                            // a flush alongside a miss only drains the old word
                            pend_valid <= 1'b1;
                            pend_addr  <= pix_word;
                            pend_data  <= pix_data;
                            pend_mask  <= pix_mask;
                            state      <= ST_WRITE;
                        end
                    end else if (flush_i || tmr_expire) begin
                        state <= ST_WRITE;
                    end else if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!ddr_busy_i) begin
                        wr_count_o <= wr_count_o + 32'd1;
                        if (pend_valid) begin
                            buf_addr   <= pend_addr;
                            buf_data   <= pend_data;
                            buf_mask   <= pend_mask;
                            pend_valid <= 1'b0;
                            tmr        <= TMR_W'(FLUSH_TIMEOUT);
                            state      <= ST_FILL;
                        end else begin
                            state <= ST_EMPTY;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_fb_writer.sv
// Bench for jpeg_fb_writer: a 32bpp instance (short flush timeout) and a 16bpp
// instance (timeout off), checked against a byte-addressed framebuffer model.
module tb_jpeg_fb_writer;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [28:0] base = '0;
    logic [13:0] stride = '0;
    logic        pix_valid = 1'b0, flush = 1'b0, busy = 1'b0;
    logic        sel16 = 1'b0, busy_rand = 1'b0;
    logic [15:0] px = '0, py = '0;
    logic [7:0]  pr = '0, pg = '0, pb = '0;

    logic        acc32, we32, idle32, acc16, we16, idle16;
    logic [28:0] addr32, addr16;
    logic [63:0] din32, din16;
    logic [7:0]  be32, be16, bc32, bc16;
    logic [31:0] cnt32, cnt16;

    logic        acc, we, idle;
    logic [28:0] addr;
    logic [63:0] din;
    logic [7:0]  be;
    logic [31:0] cnt;

    int tests_run = 0;
    int tests_failed = 0;
    wr_t wq[$];

    always #5 clk = ~clk;

    jpeg_fb_writer #(.ADDR_W(29), .COORD_W(16), .BPP(32), .FLUSH_TIMEOUT(4)) dut32 (
        .clk_i(clk), .rst_i(rst), .base_i(base), .stride_i(stride),
        .pix_valid_i(pix_valid & ~sel16), .pix_accept_o(acc32),
        .pix_x_i(px), .pix_y_i(py), .pix_r_i(pr), .pix_g_i(pg), .pix_b_i(pb),
        .flush_i(flush & ~sel16), .ddr_busy_i(busy), .ddr_we_o(we32),
        .ddr_addr_o(addr32), .ddr_din_o(din32), .ddr_be_o(be32),
        .ddr_burstcnt_o(bc32), .idle_o(idle32), .wr_count_o(cnt32));

    jpeg_fb_writer #(.ADDR_W(29), .COORD_W(16), .BPP(16), .FLUSH_TIMEOUT(0)) dut16 (
        .clk_i(clk), .rst_i(rst), .base_i(base), .stride_i(stride),
        .pix_valid_i(pix_valid & sel16), .pix_accept_o(acc16),
        .pix_x_i(px), .pix_y_i(py), .pix_r_i(pr), .pix_g_i(pg), .pix_b_i(pb),
        .flush_i(flush & sel16), .ddr_busy_i(busy), .ddr_we_o(we16),
        .ddr_addr_o(addr16), .ddr_din_o(din16), .ddr_be_o(be16),
        .ddr_burstcnt_o(bc16), .idle_o(idle16), .wr_count_o(cnt16));

    assign acc  = sel16 ? acc16  : acc32;
    assign we   = sel16 ? we16   : we32;
    assign idle = sel16 ? idle16 : idle32;
    assign addr = sel16 ? addr16 : addr32;
    assign din  = sel16 ? din16  : din32;
    assign be   = sel16 ? be16   : be32;
    assign cnt  = sel16 ? cnt16  : cnt32;

    always @(posedge clk) begin
        if (!rst && we && !busy) wq.push_back({addr, din, be});
    end

    function automatic logic [63:0] bytemask(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic rand_busy();
        if (busy_rand) busy = ($urandom_range(0, 2) == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b0; flush = 1'b0; busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
    endtask

    task automatic send_pix(input int x, input int y, input logic [7:0] r,
                            input logic [7:0] g, input logic [7:0] b, input bit fl);
        int n = 0;
        @(negedge clk);
        rand_busy();
        px = 16'(x); py = 16'(y); pr = r; pg = g; pb = b;
        pix_valid = 1'b1; flush = fl;
        while (!acc && n < 200) begin
            @(negedge clk);
            rand_busy();
            n++;
        end
        if (!acc) begin
            tests_run++; tests_failed++;
            $display("FAIL send_pix_timeout: accept=%b required 1", acc);
        end
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            rand_busy();
            pix_valid = 1'b0; flush = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic flush_when_ready();
        int n = 0;
        @(negedge clk);
        rand_busy();
        pix_valid = 1'b0; flush = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            rand_busy();
            n++;
        end
        if (!acc) begin
            tests_run++; tests_failed++;
            $display("FAIL flush_ready_timeout: accept=%b required 1", acc);
        end
        flush = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        rand_busy();
        pix_valid = 1'b0; flush = 1'b0;
        while (!idle && n < 300) begin
            @(negedge clk);
            rand_busy();
            n++;
        end
        if (!idle) begin
            tests_run++; tests_failed++;
            $display("FAIL wait_idle_timeout: idle=%b required 1", idle);
        end
    endtask

    task automatic test_reset();
        sel16 = 1'b0;
        do_reset();
        base = 29'h1234; stride = 14'd640;
        send_pix(3, 1, 8'h11, 8'h22, 8'h33, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({acc32, idle32, we32, acc16, idle16, we16} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: acc/idle/we=%b required 000000",
                     {acc32, idle32, we32, acc16, idle16, we16});
        end
        tests_run++;
        if ({addr32, din32, be32, cnt32} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h din=%h be=%h cnt=%0d required all 0",
                     addr32, din32, be32, cnt32);
        end
        tests_run++;
        if (bc32 !== 8'd1 || bc16 !== 8'd1) begin
            tests_failed++;
            $display("FAIL burstcnt: got %0d/%0d required 1", bc32, bc16);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if ({acc32, idle32, acc16, idle16} !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_release: acc/idle=%b required 1111",
                     {acc32, idle32, acc16, idle16});
        end
        wq.delete();
    endtask

    task automatic test_two_pixels();
        logic [7:0] r0, g0, b0, r1, g1, b1;
        wr_t w;
        sel16 = 1'b0;
        do_reset();
        base = 29'h100; stride = 14'd2560;
        r0 = 8'($urandom); g0 = 8'($urandom); b0 = 8'($urandom);
        r1 = 8'($urandom); g1 = 8'($urandom); b1 = 8'($urandom);
        send_pix(0, 0, r0, g0, b0, 1'b0);
        send_pix(1, 0, r1, g1, b1, 1'b0);
        flush_when_ready();
        wait_idle();
        w = (wq.size() > 0) ? wq[0] : '0;
        tests_run++;
        if (wq.size() != 1 || cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL two_pix_count: writes=%0d cnt=%0d required 1", wq.size(), cnt);
        end
        tests_run++;
        if (w.addr !== 29'h100 || w.be !== 8'hFF) begin
            tests_failed++;
            $display("FAIL two_pix_addr_be: addr=%h be=%h required 100/ff", w.addr, w.be);
        end
        tests_run++;
        if (w.din !== {8'hFF, b1, g1, r1, 8'hFF, b0, g0, r0}) begin
            tests_failed++;
            $display("FAIL two_pix_data: got %h required %h", w.din,
                     {8'hFF, b1, g1, r1, 8'hFF, b0, g0, r0});
        end
    endtask

    task automatic test_miss();
        wr_t w0, w1;
        sel16 = 1'b0;
        do_reset();
        base = 29'h100; stride = 14'd2560;
        send_pix(0, 0, 8'hA1, 8'hA2, 8'hA3, 1'b0);
        send_pix(0, 1, 8'hB1, 8'hB2, 8'hB3, 1'b0);
        flush_when_ready();
        wait_idle();
        w0 = (wq.size() > 0) ? wq[0] : '0;
        w1 = (wq.size() > 1) ? wq[1] : '0;
        tests_run++;
        if (wq.size() != 2 || cnt !== 32'd2) begin
            tests_failed++;
            $display("FAIL miss_count: writes=%0d cnt=%0d required 2", wq.size(), cnt);
        end
        tests_run++;
        if (w0 !== {29'h100, 64'h0000_0000_FFA3_A2A1, 8'h0F}) begin
            tests_failed++;
            $display("FAIL miss_first: addr=%h din=%h be=%h required 100/ffa3a2a1/0f",
                     w0.addr, w0.din, w0.be);
        end
        tests_run++;
        if (w1 !== {29'h100 + 29'd320, 64'h0000_0000_FFB3_B2B1, 8'h0F}) begin
            tests_failed++;
            $display("FAIL miss_second: addr=%h din=%h be=%h required 240/ffb3b2b1/0f",
                     w1.addr, w1.din, w1.be);
        end
    endtask

    task automatic test_bpp16();
        logic [15:0] c[4];
        logic [7:0]  r, g, b;
        wr_t w;
        sel16 = 1'b1;
        do_reset();
        base = 29'($urandom); stride = 14'd2560;
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            c[i] = {r[7:3], g[7:2], b[7:3]};
            send_pix(4 + i, 0, r, g, b, 1'b0);
        end
        flush_when_ready();
        wait_idle();
        w = (wq.size() > 0) ? wq[0] : '0;
        tests_run++;
        if (wq.size() != 1 || cnt !== 32'd1) begin
            tests_failed++;
            $display("FAIL bpp16_count: writes=%0d cnt=%0d required 1", wq.size(), cnt);
        end
        tests_run++;
        if (w.addr !== base + 29'd1 || w.be !== 8'hFF) begin
            tests_failed++;
            $display("FAIL bpp16_addr_be: addr=%h be=%h required %h/ff", w.addr, w.be, base + 29'd1);
        end
        tests_run++;
        if (w.din !== {c[3], c[2], c[1], c[0]}) begin
            tests_failed++;
            $display("FAIL bpp16_data: got %h required %h", w.din, {c[3], c[2], c[1], c[0]});
        end
        sel16 = 1'b0;
    endtask

    task automatic test_busy_hold();
        int x, y;
        longint off;
        logic [28:0] ea;
        logic [63:0] ed;
        sel16 = 1'b0;
        do_reset();
        base = 29'($urandom); stride = 14'(8 * $urandom_range(1, 400));
        x = $urandom_range(0, 300); y = $urandom_range(0, 50);
        off = longint'(y) * stride + x * 4;
        ea = 29'(longint'(base) + (off >> 3));
        ed = (off & 4) != 0 ? {8'hFF, 8'h5C, 8'h5B, 8'h5A, 32'h0} : {32'h0, 8'hFF, 8'h5C, 8'h5B, 8'h5A};
        busy = 1'b1;
        send_pix(x, y, 8'h5A, 8'h5B, 8'h5C, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0; flush = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            flush = 1'b0;
            tests_run++;
            if (we !== 1'b1 || addr !== ea || din !== ed || acc !== 1'b0) begin
                tests_failed++;
                $display("FAIL busy_hold_cycle%0d: we=%b addr=%h din=%h acc=%b required 1/%h/%h/0",
                         i, we, addr, din, acc, ea, ed);
            end
            if (i == 10) busy = 1'b0;
        end
        @(negedge clk);
        tests_run++;
        if (we !== 1'b0 || cnt !== 32'd1 || wq.size() != 1) begin
            tests_failed++;
            $display("FAIL busy_release: we=%b cnt=%0d writes=%0d required 0/1/1", we, cnt, wq.size());
        end
    endtask

    task automatic test_timeout();
        logic [4:0] seen;
        sel16 = 1'b0;
        do_reset();
        base = 29'h40; stride = 14'd64;
        send_pix(2, 3, 8'h01, 8'h02, 8'h03, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pix_valid = 1'b0; flush = 1'b0;
            seen[i] = we;
        end
        tests_run++;
        if (seen !== 5'b10000) begin
            tests_failed++;
            $display("FAIL timeout_we: we over 5 cycles=%b required 10000", seen);
        end
        @(negedge clk);
        tests_run++;
        if (idle !== 1'b1 || we !== 1'b0 || cnt !== 32'd1 || wq.size() != 1) begin
            tests_failed++;
            $display("FAIL timeout_after: idle=%b we=%b cnt=%0d required 1/0/1", idle, we, cnt);
        end
    endtask

    task automatic test_flush_combo();
        sel16 = 1'b0;
        do_reset();
        base = 29'h0; stride = 14'd64;
        send_pix(0, 0, 8'h10, 8'h11, 8'h12, 1'b0);
        send_pix(1, 0, 8'h20, 8'h21, 8'h22, 1'b1);
        send_pix(0, 2, 8'h30, 8'h31, 8'h32, 1'b0);
        send_pix(0, 3, 8'h40, 8'h41, 8'h42, 1'b1);
        @(negedge clk);
        pix_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        tests_run++;
        if (we !== 1'b0 || idle !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_miss_pending: we=%b idle=%b required 0/0", we, idle);
        end
        flush_when_ready();
        wait_idle();
        tests_run++;
        if (wq.size() != 3 || cnt !== 32'd3) begin
            tests_failed++;
            $display("FAIL flush_combo_count: writes=%0d cnt=%0d required 3", wq.size(), cnt);
        end else begin
            tests_run++;
            if ({wq[0].addr, wq[0].be, wq[1].addr, wq[1].be, wq[2].addr, wq[2].be} !==
                {29'd0, 8'hFF, 29'd16, 8'h0F, 29'd24, 8'h0F}) begin
                tests_failed++;
                $display("FAIL flush_combo_words: %h/%h %h/%h %h/%h required 0/ff 10/0f 18/0f",
                         wq[0].addr, wq[0].be, wq[1].addr, wq[1].be, wq[2].addr, wq[2].be);
            end
            tests_run++;
            if (wq[0].din !== 64'hFF22_2120_FF12_1110) begin
                tests_failed++;
                $display("FAIL flush_hit_merge: got %h required ff222120ff121110", wq[0].din);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        sel16 = 1'b0;
        do_reset();
        base = 29'h200; stride = 14'd128;
        busy = 1'b1;
        send_pix(5, 1, 8'h77, 8'h66, 8'h55, 1'b0);
        @(negedge clk);
        pix_valid = 1'b0; flush = 1'b1;
        @(posedge clk);
        idle_cycles(3);
        @(negedge clk);
        tests_run++;
        if (we !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_write_pending: we=%b required 1", we);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (we !== 1'b0 || cnt !== 32'd0 || acc !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_write_drop: we=%b cnt=%0d acc=%b required 0/0/0", we, cnt, acc);
        end
        @(negedge clk);
        rst = 1'b0; busy = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (wq.size() != 0 || we !== 1'b0 || idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_write_after: writes=%0d we=%b idle=%b required 0/0/1", wq.size(), we, idle);
        end
    endtask

    // Expected framebuffer is kept per byte address; coalescing is not modelled,
    // only the final memory image and how many word changes the pixel stream had.
    task automatic test_random(input bit is16, input int npix);
        logic [7:0] exp_b[longint];
        logic [7:0] got_b[longint];
        logic [7:0] r, g, b;
        logic [15:0] c565;
        logic [7:0] pbytes[4];
        int x = 0, y = 0, bpb, exp_w = 0, bad = 0;
        longint off, word, cur = -1;
        sel16 = is16;
        do_reset();
        bpb = is16 ? 2 : 4;
        base = ($urandom_range(0, 1) == 1) ? 29'h1FFF_FFF0 : 29'($urandom);
        stride = 14'(8 * $urandom_range(4, 40));
        busy_rand = 1'b1;
        for (int i = 0; i < npix; i++) begin
            if ($urandom_range(0, 2) != 0) x = x + 1;
            else x = $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) y = $urandom_range(0, 3);
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            off = longint'(y) * stride + longint'(x) * bpb;
            word = (longint'(base) + (off >> 3)) & 64'h1FFF_FFFF;
            c565 = {r[7:3], g[7:2], b[7:3]};
            pbytes = is16 ? '{c565[7:0], c565[15:8], 8'h0, 8'h0} : '{r, g, b, 8'hFF};
            for (int k = 0; k < bpb; k++) exp_b[word * 8 + (off & 7) + k] = pbytes[k];
            if (word != cur) begin
                if (cur >= 0) exp_w++;
                cur = word;
            end
            send_pix(x, y, r, g, b, 1'b0);
            idle_cycles($urandom_range(0, 2));
        end
        exp_w++;
        flush_when_ready();
        wait_idle();
        busy_rand = 1'b0; busy = 1'b0;
        tests_run++;
        if (wq.size() != exp_w || cnt !== 32'(exp_w)) begin
            tests_failed++;
            $display("FAIL rand%0d_writes: writes=%0d cnt=%0d required %0d",
                     bpb * 8, wq.size(), cnt, exp_w);
        end
        foreach (wq[i]) begin
            tests_run++;
            if ((wq[i].din & ~bytemask(wq[i].be)) !== 64'h0) begin
                tests_failed++;
                $display("FAIL rand%0d_lane_zero: din=%h be=%h required disabled lanes 0",
                         bpb * 8, wq[i].din, wq[i].be);
            end
            for (int k = 0; k < 8; k++)
                if (wq[i].be[k]) got_b[longint'(wq[i].addr) * 8 + k] = wq[i].din[k*8 +: 8];
        end
        tests_run++;
        if (got_b.num() != exp_b.num()) begin
            tests_failed++;
            $display("FAIL rand%0d_bytes_written: got %0d bytes required %0d",
                     bpb * 8, got_b.num(), exp_b.num());
        end
        foreach (exp_b[k]) begin
            if (!got_b.exists(k) || got_b[k] !== exp_b[k]) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rand%0d_image: %0d bytes differ, required 0", bpb * 8, bad);
        end
        sel16 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_two_pixels();
        test_miss();
        test_bpp16();
        test_busy_hold();
        test_timeout();
        test_flush_combo();
        test_reset_mid_write();
        test_random(1'b0, 300);
        test_random(1'b1, 300);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
